// File: rtl/up_run_ctrl.sv
// up_run_ctrl: run/step/load sequencer between the front panel and the CPU
// control unit of the 8-bit accumulator machine.
//   CLOCK, RESET            : clock (rising edge), async active-low reset
//   Run, Step, LoadEn, Abort: panel controls (Step is edge-detected)
//   BrkEn, BrkAddr, PC      : PC breakpoint compare
//   CpuState, CpuHalt       : CU state code and halt flag
//   LdValid, LdData, LdReady: loader byte handshake
//   mem_sel/we/addr/wdata   : loader side of the shared program memory
//   cpu_rst, cpu_en         : CU reset and clock enable
//   Mode, InstrCnt          : sequencer state and fetched-instruction count
module up_run_ctrl #(
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          Run,
  input  logic          Step,
  input  logic          LoadEn,
  input  logic          Abort,
  input  logic          BrkEn,
  input  logic [AW-1:0] BrkAddr,
  input  logic [AW-1:0] PC,
  input  logic [3:0]    CpuState,
  input  logic          CpuHalt,
  input  logic          LdValid,
  input  logic [7:0]    LdData,
  output logic          LdReady,
  output logic          mem_sel,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          cpu_rst,
  output logic          cpu_en,
  output logic [2:0]    Mode,
  output logic [CW-1:0] InstrCnt
);

  localparam logic [3:0] CU_START = 4'b0000;
  localparam logic [3:0] CU_FETCH = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_PAUSE  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stepped_q, stepped_d;
  logic          skip_q, skip_d;
  logic          step_q;
  logic          cpu_rst_q, cpu_rst_d;
  logic          ld_ready_q, ld_ready_d;
  logic          mem_sel_q, mem_sel_d;

  logic step_edge;
  logic boundary;
  logic brk;
  logic run_stop;

  // Next-state, flag and strobe logic
  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    cnt_d      = cnt_q;
    stepped_d  = stepped_q;
    skip_d     = skip_q;
    mem_we     = 1'b0;
    cpu_en     = 1'b0;
    cpu_rst_d  = 1'b1;
    ld_ready_d = 1'b0;
    mem_sel_d  = 1'b0;

    step_edge = Step & ~step_q;
    boundary  = (CpuState == CU_START);
    brk       = BrkEn & (PC == BrkAddr) & ~skip_q;
    run_stop  = boundary & (~Run | brk);

    // The breakpoint skip lasts only until the resumed instruction leaves START
    if (!boundary) skip_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (LoadEn) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
        end else if (Run) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d = S_STEP;
        end
      end
      S_LOAD: begin
        if (!LoadEn) begin
          state_d = S_IDLE;
        end else begin
          mem_we = LdValid;
          if (LdValid) begin
            ld_ptr_d = ld_ptr_q + AW'(1);
            if (ld_ptr_q == {AW{1'b1}}) state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        // Holding cpu_en low at a stopping boundary freezes the CU in START
        cpu_en = ~run_stop;
        if (CpuHalt) state_d = S_HALTED;
        else if (run_stop) state_d = S_PAUSE;
      end
      S_STEP: begin
        if (stepped_q && boundary) begin
          stepped_d = 1'b0;
          state_d   = S_PAUSE;
        end else begin
          cpu_en = 1'b1;
          if (!boundary) stepped_d = 1'b1;
        end
        if (CpuHalt) state_d = S_HALTED;
      end
      S_PAUSE: begin
        // Resuming arms skip so a breakpoint PC does not re-trigger at once
        if (LoadEn) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
        end else if (Run) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (step_edge) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end
      end
      S_HALTED: begin
        if (LoadEn) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (Abort) begin
      state_d = S_IDLE;
      mem_we  = 1'b0;
    end

    if (state_d != S_STEP) stepped_d = 1'b0;

    // Count restarts on leaving IDLE for execution, otherwise counts fetches
    if (state_q == S_IDLE && (state_d == S_RUN || state_d == S_STEP)) begin
      cnt_d = '0;
    end else if (cpu_en && CpuState == CU_FETCH && cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + CW'(1);
    end

    cpu_rst_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    ld_ready_d = (state_d == S_LOAD);
    mem_sel_d  = (state_d == S_LOAD);
  end

  // State and registered outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      ld_ptr_q   <= '0;
      cnt_q      <= '0;
      stepped_q  <= 1'b0;
      skip_q     <= 1'b0;
      step_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      ld_ready_q <= 1'b0;
      mem_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      cnt_q      <= cnt_d;
      stepped_q  <= stepped_d;
      skip_q     <= skip_d;
      step_q     <= Step;
      cpu_rst_q  <= cpu_rst_d;
      ld_ready_q <= ld_ready_d;
      mem_sel_q  <= mem_sel_d;
    end
  end

  assign Mode      = state_q;
  assign InstrCnt  = cnt_q;
  assign cpu_rst   = cpu_rst_q;
  assign LdReady   = ld_ready_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = ld_ptr_q;
  assign mem_wdata = LdData;

endmodule
